riscv_run_ctrl: RTL and testbench

//  Run-control sequencer for the single-cycle RISC-V core. Gates core progress via cpu_en
//  and accepts host commands: RUN (optional cycle limit), STEP, HALT, DUMP.

---
 rtl/riscv_run_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_riscv_run_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: run-control sequencer for the single-cycle RISC-V core.
// Gates core progress through cpu_en, executes host RUN/STEP/HALT/DUMP commands,
// stops on ecall/ebreak and streams x0..x31 over a valid/ready dump port.
// Build option: RUN_CTRL_SKIP_X0_EN -- when defined the dump starts at x1 (31 beats),
// otherwise it starts at x0 (32 beats).
module riscv_run_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             halt_req_in,
  output logic             cpu_en,
  output logic             rf_dbg_sel,
  output logic [4:0]       rf_dbg_addr,
  input  logic [XLEN-1:0]  rf_dbg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_addr,
  output logic [XLEN-1:0]  dump_data,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_ECALL = 2'd2;
  localparam logic [1:0] CAUSE_HOST  = 2'd3;

  localparam logic [4:0] DUMP_LAST = 5'd31;
`ifdef RUN_CTRL_SKIP_X0_EN
  localparam logic [4:0] DUMP_FIRST = 5'd1;
`else
  localparam logic [4:0] DUMP_FIRST = 5'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_STEP     = 3'd2,
    S_DUMP_RD  = 3'd3,
    S_DUMP_OUT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] r_run_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [1:0]       r_halt_cause;
  logic [4:0]       r_idx;
  logic [4:0]       r_dump_addr;
  logic [XLEN-1:0]  r_dump_data;

  logic             w_cmd_fire;
  logic             w_exit;
  logic [1:0]       w_exit_cause;
  logic             w_limit_hit;
  logic             w_cpu_en;
  logic             w_cmd_ready;
  logic             w_rf_dbg_sel;
  logic             w_dump_valid;
  logic             w_halted;

  // Command handshake: only IDLE and RUN ever accept a command.
  assign w_cmd_fire  = cmd_valid && ((r_state == S_IDLE) || (r_state == S_RUN));
  assign w_limit_hit = (r_limit != '0) && ((r_run_cnt + CNT_W'(1)) == r_limit);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic and halt cause selection (ecall > host HALT > limit).
  always_comb begin
    w_state_nxt  = r_state;
    w_exit       = 1'b0;
    w_exit_cause = CAUSE_NONE;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          case (cmd_op)
            OP_RUN:  w_state_nxt = S_RUN;
            OP_STEP: w_state_nxt = S_STEP;
            OP_DUMP: w_state_nxt = S_DUMP_RD;
            default: w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (halt_req_in) begin
          w_exit       = 1'b1;
          w_exit_cause = CAUSE_ECALL;
        end else if (w_cmd_fire && (cmd_op == OP_HALT)) begin
          w_exit       = 1'b1;
          w_exit_cause = CAUSE_HOST;
        end else if (w_limit_hit) begin
          w_exit       = 1'b1;
          w_exit_cause = CAUSE_LIMIT;
        end
        if (w_exit) w_state_nxt = S_IDLE;
      end
      S_STEP: begin
        w_exit       = 1'b1;
        w_exit_cause = halt_req_in ? CAUSE_ECALL : CAUSE_HOST;
        w_state_nxt  = S_IDLE;
      end
      S_DUMP_RD: begin
        w_state_nxt = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (dump_ready) w_state_nxt = (r_idx == DUMP_LAST) ? S_IDLE : S_DUMP_RD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_cpu_en     = 1'b0;
    w_cmd_ready  = 1'b0;
    w_rf_dbg_sel = 1'b0;
    w_dump_valid = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_halted    = 1'b1;
      end
      S_RUN: begin
        w_cpu_en    = 1'b1;
        w_cmd_ready = 1'b1;
      end
      S_STEP: begin
        w_cpu_en = 1'b1;
      end
      S_DUMP_RD: begin
        w_rf_dbg_sel = 1'b1;
      end
      S_DUMP_OUT: begin
        w_rf_dbg_sel = 1'b1;
        w_dump_valid = 1'b1;
      end
      default: begin
        w_halted = 1'b0;
      end
    endcase
  end

  // RUN limit latch and per-run cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_limit   <= '0;
      r_run_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_cmd_fire && (cmd_op == OP_RUN)) begin
      r_limit   <= cmd_arg;
      r_run_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_run_cnt <= r_run_cnt + CNT_W'(1);
    end
  end

  // Free-running count of enabled core cycles; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_cycle_cnt <= '0;
    else if (w_cpu_en) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
  end

  // Halt cause is only updated when RUN or STEP ends; DUMP leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_halt_cause <= CAUSE_NONE;
    else if (w_exit) r_halt_cause <= w_exit_cause;
  end

  // Dump register index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
    end else if ((r_state == S_IDLE) && w_cmd_fire && (cmd_op == OP_DUMP)) begin
      r_idx <= DUMP_FIRST;
    end else if ((r_state == S_DUMP_OUT) && dump_ready && (r_idx != DUMP_LAST)) begin
      r_idx <= r_idx + 5'd1;
    end
  end

  // Dump beat capture; holds while the sink stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dump_addr <= '0;
      r_dump_data <= '0;
    end else if (r_state == S_DUMP_RD) begin
      r_dump_addr <= r_idx;
      r_dump_data <= rf_dbg_data;
    end
  end

  assign cpu_en      = w_cpu_en;
  assign cmd_ready   = w_cmd_ready;
  assign rf_dbg_sel  = w_rf_dbg_sel;
  assign rf_dbg_addr = r_idx;
  assign dump_valid  = w_dump_valid;
  assign dump_addr   = r_dump_addr;
  assign dump_data   = r_dump_data;
  assign halted      = w_halted;
  assign halt_cause  = r_halt_cause;
  assign cycle_cnt   = r_cycle_cnt;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: table of RUN/STEP command vectors with a run scoreboard,
// plus hand sequences for STEP bursts, register dumps with back-pressure and reset.
module tb_riscv_run_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

`ifdef RUN_CTRL_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic             halt_req_in;
  logic             cpu_en;
  logic             rf_dbg_sel;
  logic [4:0]       rf_dbg_addr;
  logic [XLEN-1:0]  rf_dbg_data;
  logic             dump_valid;
  logic             dump_ready;
  logic [4:0]       dump_addr;
  logic [XLEN-1:0]  dump_data;
  logic             halted;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt;

  riscv_run_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .halt_req_in(halt_req_in), .cpu_en(cpu_en),
    .rf_dbg_sel(rf_dbg_sel), .rf_dbg_addr(rf_dbg_addr), .rf_dbg_data(rf_dbg_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .halted(halted), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // Regfile model: xi = i*4 (x0 reads 0).
  always_comb rf_dbg_data = XLEN'(rf_dbg_addr) * XLEN'(4);

  typedef struct {
    logic [1:0] op;
    int         arg;
    bit         hold;      // halt_req_in held high for the whole command
    int         halt_at;   // enabled cycle that pulses halt_req_in (0 = none)
    int         cmd_at;    // enabled cycle that presents a second command (0 = none)
    logic [1:0] cmd_op;
    int         exp_en;
    logic [1:0] exp_cause;
  } vec_t;

  typedef struct {
    int               en;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cyc;
  } run_exp_t;

  typedef struct {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } beat_t;

  run_exp_t run_q[$];
  beat_t    beat_q[$];
  vec_t     vecs[13];

  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] model_cyc = '0;
  logic [1:0]       model_cause = 2'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    int g = 0;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    run_exp_t e;
    run_exp_t got;
    int cnt = 0;
    int guard = 0;
    model_cyc   = model_cyc + CNT_W'(v.exp_en);
    model_cause = v.exp_cause;
    e.en = v.exp_en; e.cause = v.exp_cause; e.cyc = model_cyc;
    run_q.push_back(e);
    halt_req_in = v.hold;
    issue_cmd(v.op, CNT_W'(v.arg));
    while (!halted && guard < 600) begin
      if (cpu_en) cnt++;
      halt_req_in = v.hold || (cpu_en && (cnt == v.halt_at));
      cmd_valid   = cpu_en && (cnt == v.cmd_at);
      cmd_op      = v.cmd_op;
      cmd_arg     = '0;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    cmd_valid   = 1'b0;
    halt_req_in = 1'b0;
    chk($sformatf("v%0d_halted_in_budget", idx), 64'(halted), 64'd1);
    got = run_q.pop_front();
    chk($sformatf("v%0d_enabled_cycles", idx), 64'(cnt), 64'(got.en));
    chk($sformatf("v%0d_halt_cause", idx), 64'(halt_cause), 64'(got.cause));
    chk($sformatf("v%0d_cycle_cnt", idx), 64'(cycle_cnt), 64'(got.cyc));
  endtask

  task automatic do_dump(input string nm, input int stall_addr, input int stall_n);
    beat_t b;
    beat_t got;
    int beats = 0;
    int stalled = 0;
    int hold_bad = 0;
    int en_bad = 0;
    int sel_bad = 0;
    int guard = 0;
    for (int i = FIRST; i < 32; i++) begin
      b.addr = 5'(i);
      b.data = XLEN'(i * 4);
      beat_q.push_back(b);
    end
    dump_ready = 1'b1;
    issue_cmd(OP_DUMP, '0);
    while (!halted && guard < 300) begin
      if (cpu_en) en_bad++;
      if (!rf_dbg_sel) sel_bad++;
      if (dump_valid) begin
        if ((int'(dump_addr) == stall_addr) && (stalled < stall_n)) begin
          dump_ready = 1'b0;
          if (dump_data !== XLEN'(stall_addr * 4)) hold_bad++;
          stalled++;
        end else begin
          dump_ready = 1'b1;
          beats++;
          if (beat_q.size() > 0) begin
            got = beat_q.pop_front();
            chk($sformatf("%s_beat%0d", nm, beats), {27'd0, dump_addr, dump_data},
                {27'd0, got.addr, got.data});
          end else begin
            chk($sformatf("%s_extra_beat", nm), 64'(dump_addr), 64'hffff);
          end
        end
      end else begin
        dump_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    chk({nm, "_done_in_budget"}, 64'(halted), 64'd1);
    chk({nm, "_beat_count"}, 64'(beats), 64'(32 - FIRST));
    chk({nm, "_missing_beats"}, 64'(beat_q.size()), 64'd0);
    chk({nm, "_cpu_en_during_dump"}, 64'(en_bad), 64'd0);
    chk({nm, "_rf_dbg_sel_during_dump"}, 64'(sel_bad), 64'd0);
    chk({nm, "_stall_cycles"}, 64'(stalled), 64'(stall_n));
    chk({nm, "_held_beat_data"}, 64'(hold_bad), 64'd0);
    chk({nm, "_halt_cause_kept"}, 64'(halt_cause), 64'(model_cause));
    chk({nm, "_cycle_cnt_kept"}, 64'(cycle_cnt), 64'(model_cyc));
    beat_q.delete();
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_halted"}, 64'(halted), 64'd1);
    chk({nm, "_cpu_en"}, 64'(cpu_en), 64'd0);
    chk({nm, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    chk({nm, "_halt_cause"}, 64'(halt_cause), 64'd0);
    chk({nm, "_dump_valid"}, 64'(dump_valid), 64'd0);
    chk({nm, "_rf_dbg_sel"}, 64'(rf_dbg_sel), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int en_cnt;
    int consec;
    int rdy_bad;
    int g;
    logic prev_en;

    //          op       arg  hold at  cmd cmd_op   en   cause
    vecs[0]  = '{OP_RUN,  10,  0,   0,  0, OP_RUN,  10,  2'd1};
    vecs[1]  = '{OP_RUN,  0,   0,   5,  0, OP_RUN,  5,   2'd2};
    vecs[2]  = '{OP_RUN,  0,   1,   0,  0, OP_RUN,  1,   2'd2};
    vecs[3]  = '{OP_STEP, 0,   0,   0,  0, OP_RUN,  1,   2'd3};
    vecs[4]  = '{OP_STEP, 0,   1,   0,  0, OP_RUN,  1,   2'd2};
    vecs[5]  = '{OP_RUN,  0,   0,   0,  4, OP_HALT, 4,   2'd3};
    vecs[6]  = '{OP_RUN,  1,   0,   0,  0, OP_RUN,  1,   2'd1};
    vecs[7]  = '{OP_RUN,  3,   0,   3,  0, OP_RUN,  3,   2'd2};
    vecs[8]  = '{OP_RUN,  5,   0,   0,  5, OP_HALT, 5,   2'd3};
    vecs[9]  = '{OP_RUN,  0,   0,   2,  2, OP_HALT, 2,   2'd2};
    vecs[10] = '{OP_RUN,  6,   0,   0,  2, OP_STEP, 6,   2'd1};
    vecs[11] = '{OP_RUN,  0,   0,   4,  3, OP_DUMP, 4,   2'd2};
    vecs[12] = '{OP_RUN,  200, 0,   0,  0, OP_RUN,  200, 2'd1};

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_RUN; cmd_arg = '0;
    halt_req_in = 1'b0; dump_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    rst = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // HALT in IDLE is accepted and changes nothing.
    issue_cmd(OP_HALT, '0);
    @(negedge clk);
    chk("idle_halt_halted", 64'(halted), 64'd1);
    chk("idle_halt_cause", 64'(halt_cause), 64'(model_cause));
    chk("idle_halt_cycle_cnt", 64'(cycle_cnt), 64'(model_cyc));

    // Three STEPs with cmd_valid held: never two enabled cycles in a row.
    acc = 0; en_cnt = 0; consec = 0; rdy_bad = 0; prev_en = 1'b0;
    cmd_op = OP_STEP; cmd_arg = '0;
    for (int c = 0; c < 20; c++) begin
      if (cpu_en) en_cnt++;
      if (cpu_en && prev_en) consec++;
      if (cpu_en && cmd_ready) rdy_bad++;
      prev_en   = cpu_en;
      cmd_valid = (acc < 3);
      if (cmd_valid && cmd_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    model_cyc   = model_cyc + CNT_W'(3);
    model_cause = 2'd3;
    chk("step3_enabled_cycles", 64'(en_cnt), 64'd3);
    chk("step3_consecutive_en", 64'(consec), 64'd0);
    chk("step3_cmd_ready_in_step", 64'(rdy_bad), 64'd0);
    chk("step3_cycle_cnt", 64'(cycle_cnt), 64'(model_cyc));
    chk("step3_halt_cause", 64'(halt_cause), 64'd3);

    do_dump("dump_full", -1, 0);
    do_dump("dump_stall7", 7, 3);

    // Reset in the middle of an unlimited RUN.
    issue_cmd(OP_RUN, '0);
    repeat (3) @(negedge clk);
    chk("midrun_cpu_en_before_reset", 64'(cpu_en), 64'd1);
    rst = 1'b0;
    #1;
    chk_reset_state("rst_midrun");
    model_cyc = '0; model_cause = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset while a dump beat is stalled on the port.
    dump_ready = 1'b0;
    issue_cmd(OP_DUMP, '0);
    g = 0;
    while (!dump_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("middump_valid_before_reset", 64'(dump_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk_reset_state("rst_middump");
    @(negedge clk);
    rst = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);

    // Core recovers after reset; counter restarts from zero.
    run_vec(100, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
